// File: rtl/protocol_classifier_if.sv
// Byte-stream bundle between the frame source, the protocol classifier and the analyzer bank.
// The slave side is the classifier; the master side feeds bytes and observes the replayed stream.
interface protocol_classifier_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sof;
  logic       in_eof;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic [1:0] out_sel;
  logic       out_sof;
  logic       out_eof;
  logic       out_abort;

  modport slave (
    input  in_data, in_valid, in_sof, in_eof,
    output in_ready, out_data, out_valid, out_sel, out_sof, out_eof, out_abort
  );

  modport master (
    output in_data, in_valid, in_sof, in_eof,
    input  in_ready, out_data, out_valid, out_sel, out_sof, out_eof, out_abort
  );
endinterface

// File: rtl/protocol_classifier.sv
// Buffers each IPv4 header, picks the analyzer from the Protocol byte, then replays the header
// and streams the rest of the frame. The output never stalls; only the input is throttled.
module protocol_classifier #(
  parameter int HDR_BYTES = 10,
  parameter int PROTO_IDX = 9,
  parameter int CHECK_VER = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  protocol_classifier_if.slave bus,
  output logic [CNT_W-1:0]     runt_cnt,
  output logic [CNT_W-1:0]     badver_cnt
);

  localparam int IDX_W = (HDR_BYTES > 2) ? $clog2(HDR_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_BYTES - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_REPLAY = 3'd2,
    ST_PASS   = 3'd3,
    ST_DROP   = 3'd4
  } state_t;

  function automatic logic [1:0] classify(input logic [7:0] proto);
    logic [1:0] sel;
    case (proto)
      8'h06:   sel = 2'b01;
      8'h01:   sel = 2'b10;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] res;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) begin
      res = {CNT_W{1'b1}};
    end else begin
      res = sum[CNT_W-1:0];
    end
    return res;
  endfunction

  state_t           state_r, state_nx_s;
  logic [7:0]       hdr_r [HDR_BYTES];
  logic [IDX_W-1:0] idx_r, idx_nx_s;
  logic [IDX_W-1:0] rd_r, rd_nx_s;
  logic [IDX_W-1:0] wr_addr_s;
  logic             wr_en_s;
  logic             eof_hdr_r, eof_hdr_nx_s;
  logic [1:0]       sel_r, sel_nx_s;
  logic [7:0]       out_data_r, out_data_nx_s;
  logic             out_valid_r, out_valid_nx_s;
  logic             out_sof_r, out_sof_nx_s;
  logic             out_eof_r, out_eof_nx_s;
  logic             out_abort_r, out_abort_nx_s;
  logic [1:0]       runt_inc_s;
  logic             badver_inc_s;
  logic [CNT_W-1:0] runt_cnt_r, badver_cnt_r;
  logic             accept_s, sof_start_s, ver_ok_s;
  logic [7:0]       proto_s;

  assign bus.in_ready = (state_r != ST_REPLAY);
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign sof_start_s  = accept_s && bus.in_sof;
  assign ver_ok_s     = (CHECK_VER == 0) || (hdr_r[0][7:4] == 4'd4);

  // When the Protocol byte is the last header byte it has not been buffered yet.
  if (PROTO_IDX == HDR_BYTES - 1) begin : g_proto_live
    assign proto_s = bus.in_data;
  end else begin : g_proto_buf
    assign proto_s = hdr_r[PROTO_IDX];
  end

  // Next-state, buffer write and registered-output decode
  always_comb begin
    state_nx_s     = state_r;
    idx_nx_s       = idx_r;
    rd_nx_s        = rd_r;
    wr_en_s        = 1'b0;
    wr_addr_s      = idx_r;
    eof_hdr_nx_s   = eof_hdr_r;
    sel_nx_s       = sel_r;
    out_data_nx_s  = out_data_r;
    out_valid_nx_s = 1'b0;
    out_sof_nx_s   = 1'b0;
    out_eof_nx_s   = 1'b0;
    out_abort_nx_s = 1'b0;
    runt_inc_s     = 2'd0;
    badver_inc_s   = 1'b0;

    if (sof_start_s) begin
      // A sof restarts header capture from any accepting state; an open header is a runt.
      wr_en_s        = 1'b1;
      wr_addr_s      = '0;
      idx_nx_s       = ONE_IDX;
      out_abort_nx_s = (state_r == ST_PASS);
      runt_inc_s     = {1'b0, state_r == ST_HDR} + {1'b0, bus.in_eof};
      state_nx_s     = bus.in_eof ? ST_IDLE : ST_HDR;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
        end
        ST_DROP: begin
          if (accept_s && bus.in_eof) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_DROP;
          end
        end
        ST_HDR: begin
          if (accept_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = idx_r;
            if (idx_r == LAST_IDX) begin
              sel_nx_s     = classify(proto_s);
              eof_hdr_nx_s = bus.in_eof;
              rd_nx_s      = '0;
              if (ver_ok_s) begin
                state_nx_s = ST_REPLAY;
              end else begin
                badver_inc_s = 1'b1;
                state_nx_s   = bus.in_eof ? ST_IDLE : ST_DROP;
              end
            end else if (bus.in_eof) begin
              runt_inc_s = 2'd1;
              state_nx_s = ST_IDLE;
            end else begin
              idx_nx_s = idx_r + ONE_IDX;
            end
          end else begin
            state_nx_s = ST_HDR;
          end
        end
        ST_REPLAY: begin
          out_valid_nx_s = 1'b1;
          out_data_nx_s  = hdr_r[rd_r];
          out_sof_nx_s   = (rd_r == '0);
          if (rd_r == LAST_IDX) begin
            out_eof_nx_s = eof_hdr_r;
            state_nx_s   = eof_hdr_r ? ST_IDLE : ST_PASS;
          end else begin
            rd_nx_s = rd_r + ONE_IDX;
          end
        end
        ST_PASS: begin
          if (accept_s) begin
            out_valid_nx_s = 1'b1;
            out_data_nx_s  = bus.in_data;
            out_eof_nx_s   = bus.in_eof;
            state_nx_s     = bus.in_eof ? ST_IDLE : ST_PASS;
          end else begin
            state_nx_s = ST_PASS;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Header buffer, indices, output registers and saturating error counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < HDR_BYTES; i++) begin
        hdr_r[i] <= 8'h00;
      end
      idx_r        <= '0;
      rd_r         <= '0;
      eof_hdr_r    <= 1'b0;
      sel_r        <= 2'b00;
      out_data_r   <= 8'h00;
      out_valid_r  <= 1'b0;
      out_sof_r    <= 1'b0;
      out_eof_r    <= 1'b0;
      out_abort_r  <= 1'b0;
      runt_cnt_r   <= '0;
      badver_cnt_r <= '0;
    end else begin
      if (wr_en_s) begin
        hdr_r[wr_addr_s] <= bus.in_data;
      end
      idx_r        <= idx_nx_s;
      rd_r         <= rd_nx_s;
      eof_hdr_r    <= eof_hdr_nx_s;
      sel_r        <= sel_nx_s;
      out_data_r   <= out_data_nx_s;
      out_valid_r  <= out_valid_nx_s;
      out_sof_r    <= out_sof_nx_s;
      out_eof_r    <= out_eof_nx_s;
      out_abort_r  <= out_abort_nx_s;
      runt_cnt_r   <= sat_add(runt_cnt_r, runt_inc_s);
      badver_cnt_r <= sat_add(badver_cnt_r, {1'b0, badver_inc_s});
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sel   = sel_r;
  assign bus.out_sof   = out_sof_r;
  assign bus.out_eof   = out_eof_r;
  assign bus.out_abort = out_abort_r;
  assign runt_cnt      = runt_cnt_r;
  assign badver_cnt    = badver_cnt_r;

endmodule
